stage5_wb: RTL and testbench

- Write-back stage of the 5-stage MIPS pipeline; the producer side of the register-file write port consumed by stage2_id (reg_wr_en / reg_wr_addr / reg_wr_data).
- Holds the MEM/WB pipeline register and selects the result: ALU, aligned/extended load data, or link address.
- Suppresses illegal writes, flags misaligned loads, and counts retired instructions.
- Also exports the WB result for forwarding into EX.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/stage5_wb_if.sv | 37 +++
 rtl/load_aligner.sv | 43 ++++
 rtl/pipe_reg.sv | 26 ++
 rtl/stage5_wb.sv | 98 +++++++++
 tb/tb_stage5_wb.sv | 252 +++++++++++++++++++++++++
 6 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: result-select and load-type encodings, datapath widths.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pipe_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // Write-back result select
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  // Load types; encodings 5..7 behave as lw
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

endpackage

// File: rtl/stage5_wb_if.sv
// MEM->WB instruction fields plus the register-file write port and status outputs.
// Latency: none (wiring only).
// Backpressure: none; stalls travel on the separate hold/flush scalars.
interface stage5_wb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  valid_in;
  logic                  reg_wr_en_in;
  logic [ADDR_WIDTH-1:0] reg_wr_addr_in;
  logic [DATA_WIDTH-1:0] alu_result_in;
  logic [DATA_WIDTH-1:0] mem_rd_data_in;
  logic [DATA_WIDTH-1:0] pc_plus8_in;
  logic [1:0]            wb_sel_in;
  logic [2:0]            ld_type_in;

  logic                  reg_wr_en;
  logic [ADDR_WIDTH-1:0] reg_wr_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic                  align_err;
  logic [CNT_WIDTH-1:0]  retire_cnt;

  // MEM side drives the instruction and observes the write port
  modport master (
    output valid_in, reg_wr_en_in, reg_wr_addr_in, alu_result_in,
           mem_rd_data_in, pc_plus8_in, wb_sel_in, ld_type_in,
    input  reg_wr_en, reg_wr_addr, reg_wr_data, align_err, retire_cnt
  );

  // WB stage consumes the instruction and produces the write port
  modport slave (
    input  valid_in, reg_wr_en_in, reg_wr_addr_in, alu_result_in,
           mem_rd_data_in, pc_plus8_in, wb_sel_in, ld_type_in,
    output reg_wr_en, reg_wr_addr, reg_wr_data, align_err, retire_cnt
  );
endinterface

// File: rtl/load_aligner.sv
// Extracts and extends a byte/half/word from a little-endian memory word; flags misalignment.
// Latency: combinational.
// Backpressure: none.
module load_aligner
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            off,
  input  logic [2:0]            ld_type,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, then extension chosen by load type; unknown types act as lw
  always_comb begin
    byte_v   = word[{off, 3'b000} +: 8];
    half_v   = off[1] ? word[31:16] : word[15:0];
    data     = word;
    misalign = 1'b0;
    case (ld_type)
      LD_LB:  data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      LD_LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      LD_LH: begin
        data     = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
        misalign = off[0];
      end
      LD_LHU: begin
        data     = {{(DATA_WIDTH-16){1'b0}}, half_v};
        misalign = off[0];
      end
      default: begin
        data     = word;
        misalign = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/pipe_reg.sv
// Pipeline register with synchronous reset, clear and hold; clear wins over hold.
// Latency: 1 cycle.
// Backpressure: hold freezes the contents; clear forces zero regardless of hold.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Priority: reset, then clear, then hold, else capture
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stage5_wb.sv
// Write-back stage: MEM/WB register, result select, $0/misalign write suppression, retire counter.
// Latency: 1 cycle from MEM inputs to reg_wr_* outputs.
// Backpressure: hold freezes MEM/WB and the counter; flush inserts a bubble and overrides hold.
module stage5_wb
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = pipe_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = pipe_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        hold,
  input  logic        flush,
  stage5_wb_if.slave  wb
);

  localparam int FW = 1 + ADDR_WIDTH + 3*DATA_WIDTH + 2 + 3;

  logic                  valid_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] pc8_q;
  logic [1:0]            wb_sel_q;
  logic [2:0]            ld_type_q;

  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_misalign;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] result;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // Payload fields only honour hold; their contents are irrelevant once flushed
  pipe_reg #(.W(FW)) u_fields (
    .clk  (clk),
    .rst  (rstb),
    .clr  (1'b0),
    .hold (hold),
    .d    ({wb.reg_wr_en_in, wb.reg_wr_addr_in, wb.alu_result_in,
            wb.mem_rd_data_in, wb.pc_plus8_in, wb.wb_sel_in, wb.ld_type_in}),
    .q    ({wr_en_q, wr_addr_q, alu_q, mem_q, pc8_q, wb_sel_q, ld_type_q})
  );

  // Valid bit is cleared by flush even while held
  pipe_reg #(.W(1)) u_valid (
    .clk  (clk),
    .rst  (rstb),
    .clr  (flush),
    .hold (hold),
    .d    (wb.valid_in),
    .q    (valid_q)
  );

  load_aligner #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .word     (mem_q),
    .off      (alu_q[1:0]),
    .ld_type  (ld_type_q),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  // Result select and write qualification, purely from registered state
  always_comb begin
    case (wb_sel_q)
      WB_SEL_LOAD: result = ld_data;
      WB_SEL_LINK: result = pc8_q;
      default:     result = alu_q;
    endcase
    misalign       = valid_q && (wb_sel_q == WB_SEL_LOAD) && ld_misalign;
    wb.reg_wr_en   = valid_q && wr_en_q && (wr_addr_q != '0) && !misalign;
    wb.reg_wr_addr = wr_addr_q;
    wb.reg_wr_data = valid_q ? result : '0;
    wb.align_err   = err_q || misalign;
    wb.retire_cnt  = cnt_q;
  end

  // Sticky misalign flag; the live term above makes it visible in the offending cycle
  always_ff @(posedge clk) begin
    if (rstb) begin
      err_q <= 1'b0;
    end else if (misalign) begin
      err_q <= 1'b1;
    end
  end

  // An instruction retires on the edge it leaves WB, i.e. when not held
  always_ff @(posedge clk) begin
    if (rstb) begin
      cnt_q <= '0;
    end else if (valid_q && !hold) begin
      cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_stage5_wb.sv
// Directed bench for stage5_wb with a queue-based expectation model.
// Latency: checks one cycle after capture.
// Backpressure: exercises hold, flush and their combination.
module tb_stage5_wb;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rstb, hold, flush;
  always #5 clk = ~clk;

  stage5_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) wbm ();
  stage5_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(3))  wbs ();

  // The narrow-counter copy sees the same instruction stream
  assign wbs.valid_in       = wbm.valid_in;
  assign wbs.reg_wr_en_in   = wbm.reg_wr_en_in;
  assign wbs.reg_wr_addr_in = wbm.reg_wr_addr_in;
  assign wbs.alu_result_in  = wbm.alu_result_in;
  assign wbs.mem_rd_data_in = wbm.mem_rd_data_in;
  assign wbs.pc_plus8_in    = wbm.pc_plus8_in;
  assign wbs.wb_sel_in      = wbm.wb_sel_in;
  assign wbs.ld_type_in     = wbm.ld_type_in;

  stage5_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rstb(rstb), .hold(hold), .flush(flush), .wb(wbm)
  );
  stage5_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(3)) dut_small (
    .clk(clk), .rstb(rstb), .hold(hold), .flush(flush), .wb(wbs)
  );

  typedef struct packed {
    logic        v;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic        addr_known;
  logic        sticky;
  logic [31:0] exp_cnt;
  int          tests;
  int          fails;

  function automatic exp_t model(logic v, logic we, logic [4:0] a, logic [31:0] alu,
                                 logic [31:0] mem, logic [31:0] pc, logic [1:0] sel,
                                 logic [2:0] ld);
    exp_t        e;
    logic [1:0]  off;
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] lv;
    logic        mis;
    off = alu[1:0];
    sh  = mem >> (8 * off);
    b   = sh[7:0];
    h   = off[1] ? mem[31:16] : mem[15:0];
    if (ld == 3'd1)      lv = {{24{b[7]}}, b};
    else if (ld == 3'd2) lv = {24'h0, b};
    else if (ld == 3'd3) lv = {{16{h[15]}}, h};
    else if (ld == 3'd4) lv = {16'h0, h};
    else                 lv = mem;
    if (ld == 3'd3 || ld == 3'd4)      mis = off[0];
    else if (ld == 3'd1 || ld == 3'd2) mis = 1'b0;
    else                               mis = (off != 2'd0);
    mis    = v && (sel == 2'd1) && mis;
    e.v    = v;
    e.addr = a;
    e.mis  = mis;
    e.en   = v && we && (a != 5'd0) && !mis;
    if (!v)              e.data = 32'h0;
    else if (sel == 2'd1) e.data = lv;
    else if (sel == 2'd2) e.data = pc;
    else                 e.data = alu;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ins(input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [1:0] sel, input logic [2:0] ld);
    wbm.valid_in       = v;
    wbm.reg_wr_en_in   = we;
    wbm.reg_wr_addr_in = a;
    wbm.alu_result_in  = alu;
    wbm.mem_rd_data_in = mem;
    wbm.pc_plus8_in    = pc;
    wbm.wb_sel_in      = sel;
    wbm.ld_type_in     = ld;
  endtask

  // One clock: push the captured instruction, advance the model, compare
  task automatic tick();
    if (!rstb && !flush && !hold)
      sb.push_back(model(wbm.valid_in, wbm.reg_wr_en_in, wbm.reg_wr_addr_in,
                         wbm.alu_result_in, wbm.mem_rd_data_in, wbm.pc_plus8_in,
                         wbm.wb_sel_in, wbm.ld_type_in));
    if (rstb) begin
      exp_cnt = 32'h0;
      sticky  = 1'b0;
    end else begin
      if (cur.v && !hold) exp_cnt = exp_cnt + 32'h1;
      if (cur.mis) sticky = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rstb) begin
      cur        = '0;
      addr_known = 1'b1;
      sb.delete();
    end else if (flush) begin
      cur.v      = 1'b0;
      cur.en     = 1'b0;
      cur.data   = 32'h0;
      cur.mis    = 1'b0;
      addr_known = 1'b0;
    end else if (!hold) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
      end else begin
        cur        = sb.pop_front();
        addr_known = 1'b1;
      end
    end
    chk("wr_en", {31'h0, wbm.reg_wr_en}, {31'h0, cur.en});
    chk("wr_data", wbm.reg_wr_data, cur.data);
    if (addr_known) chk("wr_addr", {27'h0, wbm.reg_wr_addr}, {27'h0, cur.addr});
    chk("align_err", {31'h0, wbm.align_err}, {31'h0, sticky | cur.mis});
    chk("retire_cnt", wbm.retire_cnt, exp_cnt);
    chk("retire_cnt_w3", {29'h0, wbs.retire_cnt}, {29'h0, exp_cnt[2:0]});
  endtask

  logic [1:0]  ld_off [5] = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd0};
  logic [2:0]  ld_typ [5] = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'h80FF_7F01};

  initial begin
    tests      = 0;
    fails      = 0;
    cur        = '0;
    sticky     = 1'b0;
    exp_cnt    = 32'h0;
    addr_known = 1'b0;
    rstb       = 1'b1;
    hold       = 1'b0;
    flush      = 1'b0;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rstb = 1'b0;

    // ALU write, then a bubble to let it retire
    set_ins(1, 1, 5'd8, 32'h1234_5678, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
    tick();
    chk("alu_data_const", wbm.reg_wr_data, 32'h1234_5678);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("alu_retired_const", wbm.retire_cnt, 32'd1);

    // Load extraction
    for (int i = 0; i < 5; i++) begin
      set_ins(1, 1, 5'd9, {30'h0400_0000, ld_off[i]}, 32'h80FF_7F01, 32'h0, WB_SEL_LOAD, ld_typ[i]);
      tick();
      chk("load_const", wbm.reg_wr_data, ld_exp[i]);
    end

    // Misaligned halfword, then valid writes that must not clear the flag
    set_ins(1, 1, 5'd10, 32'h0000_1001, 32'h80FF_7F01, 32'h0, WB_SEL_LOAD, LD_LH);
    tick();
    chk("misalign_en_const", {31'h0, wbm.reg_wr_en}, 32'd0);
    chk("misalign_err_const", {31'h0, wbm.align_err}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      set_ins(1, 1, 5'(i + 1), 32'h111 * i, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
      tick();
      chk("err_sticky_const", {31'h0, wbm.align_err}, 32'd1);
    end

    // Type 6 acts as lw; misaligned lw; $0 suppression; jal link; reserved select
    set_ins(1, 1, 5'd3, 32'h0000_2000, 32'hA5A5_0F0F, 32'h0, WB_SEL_LOAD, 3'd6);
    tick();
    set_ins(1, 1, 5'd3, 32'h0000_2002, 32'hA5A5_0F0F, 32'h0, WB_SEL_LOAD, LD_LW);
    tick();
    set_ins(1, 1, 5'd0, 32'h0000_DEAD, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
    tick();
    chk("zero_reg_const", {31'h0, wbm.reg_wr_en}, 32'd0);
    set_ins(1, 1, 5'd31, 32'h0000_0005, 32'h0, 32'h0040_0010, WB_SEL_LINK, LD_LW);
    tick();
    chk("jal_const", wbm.reg_wr_data, 32'h0040_0010);
    set_ins(1, 1, 5'd4, 32'hCAFE_0003, 32'h1, 32'h2, 2'd3, LD_LW);
    tick();

    // Hold for three cycles, then release
    set_ins(1, 1, 5'd12, 32'hAAAA_5555, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
    tick();
    set_ins(1, 1, 5'd13, 32'h0000_BBBB, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
    hold = 1'b1;
    repeat (3) tick();
    chk("hold_data_const", wbm.reg_wr_data, 32'hAAAA_5555);
    hold = 1'b0;
    tick();

    // Hold and flush together, then flush alone
    hold  = 1'b1;
    flush = 1'b1;
    tick();
    chk("holdflush_en_const", {31'h0, wbm.reg_wr_en}, 32'd0);
    chk("holdflush_data_const", wbm.reg_wr_data, 32'd0);
    hold  = 1'b0;
    flush = 1'b0;
    set_ins(1, 1, 5'd14, 32'h0000_0014, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Reset with a valid write in WB
    set_ins(1, 1, 5'd7, 32'h0000_0077, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
    tick();
    rstb = 1'b1;
    tick();
    chk("reset_cnt_const", wbm.retire_cnt, 32'd0);
    chk("reset_err_const", {31'h0, wbm.align_err}, 32'd0);
    rstb = 1'b0;

    // Eight retirements wrap the 3-bit counter back to zero
    for (int i = 0; i < 8; i++) begin
      set_ins(1, 1, 5'd20, 32'h100 + i, 32'h0, 32'h0, WB_SEL_ALU, LD_LW);
      tick();
    end
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap_const", {29'h0, wbs.retire_cnt}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
